fft_8p_ctrl: RTL

Frame sequencer for the 8-point pipelined FFT datapath (fft_8p).
- Collects N complex samples from a serial valid/ready stream into a parallel input buffer and holds them stable for the FFT pipeline latency.
- Captures the parallel FFT result into an output buffer and streams it out serially in bin order.
- Input and output buffers are separate, so loading of frame k+1 overlaps unloading of frame k.

---
 rtl/fft_8p_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fft_8p_ctrl.sv
// Frame sequencer for the 8-point FFT: serial samples fill a parallel input buffer that is
// held for the FFT latency; the parallel result is captured and streamed out in bin order.
module fft_8p_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int N           = 8,
    parameter int FFT_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_real,
    input  logic signed [DATA_WIDTH-1:0] s_imag,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_real,
    output logic signed [DATA_WIDTH-1:0] m_imag,
    output logic [$clog2(N)-1:0]         m_index,
    output logic                         m_last,
    output logic                         fft_start,
    output logic [N*DATA_WIDTH-1:0]      fft_x_real,
    output logic [N*DATA_WIDTH-1:0]      fft_x_imag,
    input  logic [N*DATA_WIDTH-1:0]      fft_X_real,
    input  logic [N*DATA_WIDTH-1:0]      fft_X_imag,
    output logic                         busy
);
    localparam int CW = $clog2(N);
    localparam int WW = (FFT_LATENCY < 1) ? 1 : $clog2(FFT_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [WW-1:0] WCNT_SAT = WW'(FFT_LATENCY);

    typedef enum logic {ST_LOAD, ST_WAIT} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  icnt_q, icnt_d;
    logic [WW-1:0]                  wcnt_q, wcnt_d;
    logic [CW-1:0]                  ocnt_q, ocnt_d;
    logic                           out_busy_q, out_busy_d;
    logic                           fft_start_q, fft_start_d;
    logic signed [DATA_WIDTH-1:0]   ibuf_re_q [N];
    logic signed [DATA_WIDTH-1:0]   ibuf_im_q [N];
    logic signed [DATA_WIDTH-1:0]   obuf_re_q [N];
    logic signed [DATA_WIDTH-1:0]   obuf_im_q [N];
    logic                           s_hs, m_hs, capture;

    // Capture needs the output buffer free as seen in the register, so a final output
    // handshake and a capture can never share an edge.
    always_comb begin
        s_hs        = s_valid && (state_q == ST_LOAD);
        m_hs        = out_busy_q && m_ready;
        capture     = (state_q == ST_WAIT) && (wcnt_q == WCNT_SAT) && !out_busy_q;
        state_d     = state_q;
        icnt_d      = icnt_q;
        wcnt_d      = wcnt_q;
        ocnt_d      = ocnt_q;
        out_busy_d  = out_busy_q;
        fft_start_d = 1'b0;

        case (state_q)
            ST_LOAD: begin
                if (s_hs) begin
                    if (icnt_q == CNT_LAST) begin
                        icnt_d      = '0;
                        wcnt_d      = '0;
                        fft_start_d = 1'b1;
                        state_d     = ST_WAIT;
                    end else begin
                        icnt_d = icnt_q + CW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q != WCNT_SAT) begin
                    wcnt_d = wcnt_q + WW'(1);
                end
                if (capture) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (capture) begin
            out_busy_d = 1'b1;
            ocnt_d     = '0;
        end else if (m_hs) begin
            if (ocnt_q == CNT_LAST) begin
                out_busy_d = 1'b0;
                ocnt_d     = '0;
            end else begin
                ocnt_d = ocnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= ST_LOAD;
            icnt_q      <= '0;
            wcnt_q      <= '0;
            ocnt_q      <= '0;
            out_busy_q  <= 1'b0;
            fft_start_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                ibuf_re_q[i] <= '0;
                ibuf_im_q[i] <= '0;
                obuf_re_q[i] <= '0;
                obuf_im_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            icnt_q      <= icnt_d;
            wcnt_q      <= wcnt_d;
            ocnt_q      <= ocnt_d;
            out_busy_q  <= out_busy_d;
            fft_start_q <= fft_start_d;
            if (s_hs) begin
                ibuf_re_q[icnt_q] <= s_real;
                ibuf_im_q[icnt_q] <= s_imag;
            end
            if (capture) begin
                for (int i = 0; i < N; i++) begin
                    obuf_re_q[i] <= fft_X_real[i*DATA_WIDTH +: DATA_WIDTH];
                    obuf_im_q[i] <= fft_X_imag[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // The FFT sees the input buffer continuously; it only means something while frozen in WAIT.
    always_comb begin
        fft_x_real = '0;
        fft_x_imag = '0;
        for (int i = 0; i < N; i++) begin
            fft_x_real[i*DATA_WIDTH +: DATA_WIDTH] = ibuf_re_q[i];
            fft_x_imag[i*DATA_WIDTH +: DATA_WIDTH] = ibuf_im_q[i];
        end
    end

    assign s_ready   = (state_q == ST_LOAD);
    assign m_valid   = out_busy_q;
    assign m_real    = obuf_re_q[ocnt_q];
    assign m_imag    = obuf_im_q[ocnt_q];
    assign m_index   = ocnt_q;
    assign m_last    = out_busy_q && (ocnt_q == CNT_LAST);
    assign fft_start = fft_start_q;
    assign busy      = (state_q != ST_LOAD) || out_busy_q;

endmodule
